// File: rtl/vcd_cap_pkg.sv
// Shared record encodings and pack/unpack helpers for the value-change recorder.
// Records are laid out as {kind, time, value}, most significant field first.
package vcd_cap_pkg;

   typedef enum logic [1:0] {
      KIND_CHANGE = 2'd0,
      KIND_SNAP   = 2'd1,
      KIND_OFF    = 2'd2,
      KIND_RESYNC = 2'd3
   } kind_t;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_LOST   = 1'b1
   } ovf_state_t;

   localparam int DEF_WIDTH = 3;
   localparam int DEF_TS_W  = 16;
   localparam int REC_W     = 2 + DEF_TS_W + DEF_WIDTH;
   localparam int REC_MAX_W = 64;

   function automatic int rec_width(input int width, input int ts_w);
      return 2 + ts_w + width;
   endfunction

   function automatic logic [REC_MAX_W-1:0] field_mask(input int w);
      return (w >= REC_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   // Helpers work on a 64-bit carrier so any WIDTH/TS_W combination up to 64 bits fits.
   function automatic logic [REC_MAX_W-1:0] pack_rec(input kind_t kind,
                                                      input logic [REC_MAX_W-1:0] time_v,
                                                      input logic [REC_MAX_W-1:0] value,
                                                      input int ts_w, input int width);
      return ({62'd0, kind} << (ts_w + width))
           | ((time_v & field_mask(ts_w)) << width)
           | (value & field_mask(width));
   endfunction

   function automatic kind_t unpack_kind(input logic [REC_MAX_W-1:0] rec,
                                         input int ts_w, input int width);
      logic [REC_MAX_W-1:0] sh;
      sh = rec >> (ts_w + width);
      return kind_t'(sh[1:0]);
   endfunction

   function automatic logic [REC_MAX_W-1:0] unpack_time(input logic [REC_MAX_W-1:0] rec,
                                                        input int ts_w, input int width);
      return (rec >> width) & field_mask(ts_w);
   endfunction

   function automatic logic [REC_MAX_W-1:0] unpack_value(input logic [REC_MAX_W-1:0] rec,
                                                         input int width);
      return rec & field_mask(width);
   endfunction

endpackage

// File: rtl/vcd_change_capture_fifo.sv
// Synchronous record FIFO with combinational head read; push is accepted when full
// provided a pop happens on the same edge.
module capture_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/vcd_change_capture.sv
// Timestamped value-change recorder: picks at most one record per edge, queues it,
// and tracks lost records with a NORMAL/LOST recovery machine.
module vcd_change_capture
   import vcd_cap_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int TS_W  = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] probe,
   input  logic             dump_on,
   input  logic             dump_off,
   input  logic             dump_all,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_kind,
   output logic [TS_W-1:0]  out_time,
   output logic [WIDTH-1:0] out_value,
   output logic             enabled,
   output logic             overflow,
   output logic [7:0]       drop_cnt
);
   localparam int LREC_W = rec_width(WIDTH, TS_W);

   logic [TS_W-1:0]   ts_reg;
   logic [WIDTH-1:0]  prev_reg;
   logic              enabled_reg;
   logic              overflow_reg;
   logic [7:0]        drop_cnt_reg;
   ovf_state_t        state_reg;

   logic              cand_valid;
   kind_t             cand_kind;
   logic              enabled_next;
   logic              push;
   kind_t             push_kind;
   logic              drop;
   ovf_state_t        state_next;

   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              space;
   logic [LREC_W-1:0] push_rec;
   logic [LREC_W-1:0] head_rec;

   assign pop   = out_ready && !fifo_empty;
   assign space = !fifo_full || pop;

   // Candidate selection: pulses outrank a plain change, dump_on outranks dump_off.
   always_comb begin
      cand_valid   = 1'b0;
      cand_kind    = KIND_CHANGE;
      enabled_next = enabled_reg;
      if (dump_on) begin
         cand_valid   = 1'b1;
         cand_kind    = KIND_SNAP;
         enabled_next = 1'b1;
      end else if (dump_off && enabled_reg) begin
         cand_valid   = 1'b1;
         cand_kind    = KIND_OFF;
         enabled_next = 1'b0;
      end else if (dump_all && enabled_reg) begin
         cand_valid   = 1'b1;
         cand_kind    = KIND_SNAP;
      end else if (enabled_reg && (probe != prev_reg)) begin
         cand_valid   = 1'b1;
         cand_kind    = KIND_CHANGE;
      end
   end

   always_comb begin
      push       = 1'b0;
      push_kind  = cand_kind;
      drop       = 1'b0;
      state_next = state_reg;
      case (state_reg)
         ST_NORMAL: begin
            if (cand_valid) begin
               if (space) begin
                  push = 1'b1;
               end else begin
                  drop       = 1'b1;
                  state_next = ST_LOST;
               end
            end
         end
         default: begin
            // Recovery marker takes the slot of whatever candidate arrived, except OFF.
            if (space && enabled_reg) begin
               push       = 1'b1;
               push_kind  = (cand_valid && cand_kind == KIND_OFF) ? KIND_OFF : KIND_RESYNC;
               state_next = ST_NORMAL;
            end else if (cand_valid) begin
               drop = 1'b1;
            end
         end
      endcase
   end

   assign push_rec = LREC_W'(pack_rec(push_kind, 64'(ts_reg), 64'(probe), TS_W, WIDTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_reg       <= '0;
         prev_reg     <= probe;
         enabled_reg  <= 1'b1;
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
         state_reg    <= ST_NORMAL;
      end else begin
         ts_reg      <= ts_reg + 1'b1;
         prev_reg    <= probe;
         enabled_reg <= enabled_next;
         state_reg   <= state_next;
         if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 1'b1;
         end
      end
   end

   capture_fifo #(
      .W     (LREC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_rec),
      .pop   (pop),
      .dout  (head_rec),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Stale RAM contents never leak out: fields read as zero while the queue is empty.
   assign out_valid = !fifo_empty;
   assign out_kind  = out_valid ? unpack_kind(64'(head_rec), TS_W, WIDTH) : KIND_CHANGE;
   assign out_time  = out_valid ? TS_W'(unpack_time(64'(head_rec), TS_W, WIDTH)) : '0;
   assign out_value = out_valid ? WIDTH'(unpack_value(64'(head_rec), WIDTH)) : '0;
   assign enabled   = enabled_reg;
   assign overflow  = overflow_reg;
   assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_vcd_change_capture.sv
// Directed bench for vcd_change_capture: hand-computed records for each scenario.
module tb_vcd_change_capture;
   localparam logic [1:0] K_CHANGE = 2'd0;
   localparam logic [1:0] K_SNAP   = 2'd1;
   localparam logic [1:0] K_OFF    = 2'd2;
   localparam logic [1:0] K_RESYNC = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  probe = 3'b000;
   logic        dump_on = 1'b0;
   logic        dump_off = 1'b0;
   logic        dump_all = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_kind;
   logic [15:0] out_time;
   logic [2:0]  out_value;
   logic        enabled;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int checks   = 0;
   int failures = 0;
   int cur_ts   = 0;
   logic [21:0] got;
   logic [21:0] exp;

   vcd_change_capture #(.WIDTH(3), .TS_W(16), .DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .probe     (probe),
      .dump_on   (dump_on),
      .dump_off  (dump_off),
      .dump_all  (dump_all),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_kind  (out_kind),
      .out_time  (out_time),
      .out_value (out_value),
      .enabled   (enabled),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // One edge; outputs are sampled 1 ns after it. cur_ts is the stamp of the next edge.
   task automatic tick();
      logic r;
      r = rst;
      if (out_valid && out_ready)
         $display("pop kind=%0d time=%0d value=%b", out_kind, out_time, out_value);
      @(posedge clk);
      #1;
      if (r) cur_ts = 0;
      else   cur_ts = cur_ts + 1;
   endtask

   task automatic test_reset();
      rst = 1'b1; probe = 3'b000; out_ready = 1'b1;
      tick();
      rst = 1'b0;
      got = {out_valid, out_kind, out_time, out_value}; exp = '0; checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_head got=%h exp=%h", got, exp); end
      checks++;
      if (enabled !== 1'b1) begin failures++; $display("FAIL reset_enabled got=%b exp=1", enabled); end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++;
      if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
   endtask

   task automatic test_change();
      repeat (5) tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL no_spurious got=%b exp=0", out_valid); end
      probe = 3'b001;
      tick();
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_CHANGE, 16'd5, 3'b001}; checks++;
      if (got !== exp) begin failures++; $display("FAIL change_rec got=%h exp=%h", got, exp); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL change_single got=%b exp=0", out_valid); end
   endtask

   task automatic test_dump_off_on();
      while (cur_ts < 10) tick();
      dump_off = 1'b1;
      tick();
      dump_off = 1'b0;
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_OFF, 16'd10, 3'b001}; checks++;
      if (got !== exp) begin failures++; $display("FAIL off_rec got=%h exp=%h", got, exp); end
      for (int i = 0; i < 3; i++) begin
         probe = 3'(2 + i);
         tick();
         got = {20'd0, out_valid, enabled}; exp = 22'd0; checks++;
         if (got !== exp) begin failures++; $display("FAIL off_quiet step=%0d got=%h exp=%h", i, got, exp); end
      end
      probe = 3'b101; dump_on = 1'b1;
      tick();
      dump_on = 1'b0;
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_SNAP, 16'd14, 3'b101}; checks++;
      if (got !== exp) begin failures++; $display("FAIL on_snap got=%h exp=%h", got, exp); end
      checks++;
      if (enabled !== 1'b1) begin failures++; $display("FAIL on_enabled got=%b exp=1", enabled); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL on_single got=%b exp=0", out_valid); end
   endtask

   task automatic test_snapshot_merge();
      while (cur_ts < 20) tick();
      probe = 3'b110; dump_all = 1'b1;
      tick();
      dump_all = 1'b0;
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_SNAP, 16'd20, 3'b110}; checks++;
      if (got !== exp) begin failures++; $display("FAIL all_snap got=%h exp=%h", got, exp); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL all_single got=%b exp=0", out_valid); end
      dump_on = 1'b1; dump_off = 1'b1;
      tick();
      dump_on = 1'b0; dump_off = 1'b0;
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_SNAP, 16'd22, 3'b110}; checks++;
      if (got !== exp) begin failures++; $display("FAIL onoff_snap got=%h exp=%h", got, exp); end
      tick();
      got = {20'd0, out_valid, enabled}; exp = 22'd1; checks++;
      if (got !== exp) begin failures++; $display("FAIL onoff_after got=%h exp=%h", got, exp); end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         probe = 3'(7 + i);
         tick();
      end
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_CHANGE, 16'd24, 3'b111}; checks++;
      if (got !== exp) begin failures++; $display("FAIL ovf_head got=%h exp=%h", got, exp); end
      checks++;
      if ({overflow, drop_cnt} !== {1'b1, 8'd4}) begin
         failures++; $display("FAIL ovf_count got=%b/%0d exp=1/4", overflow, drop_cnt);
      end
      out_ready = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         got = {out_valid, out_kind, out_time, out_value};
         exp = {1'b1, K_CHANGE, 16'(24 + k), 3'(7 + k)}; checks++;
         if (got !== exp) begin failures++; $display("FAIL drain k=%0d got=%h exp=%h", k, got, exp); end
      end
      tick();
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_RESYNC, 16'd36, 3'b010}; checks++;
      if (got !== exp) begin failures++; $display("FAIL resync got=%h exp=%h", got, exp); end
      checks++;
      if ({overflow, drop_cnt} !== {1'b1, 8'd4}) begin
         failures++; $display("FAIL ovf_hold got=%b/%0d exp=1/4", overflow, drop_cnt);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      probe = 3'b000; rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         probe = 3'(i + 1);
         tick();
      end
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_CHANGE, 16'd0, 3'b001}; checks++;
      if (got !== exp) begin failures++; $display("FAIL full_head got=%h exp=%h", got, exp); end
      out_ready = 1'b1; probe = 3'b101;
      tick();
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_CHANGE, 16'd1, 3'b010}; checks++;
      if (got !== exp) begin failures++; $display("FAIL pushpop_head got=%h exp=%h", got, exp); end
      checks++;
      if ({overflow, drop_cnt} !== 9'd0) begin
         failures++; $display("FAIL pushpop_nodrop got=%b/%0d exp=0/0", overflow, drop_cnt);
      end
      for (int k = 2; k <= 7; k++) begin
         tick();
         got = {out_valid, out_kind, out_time, out_value};
         exp = {1'b1, K_CHANGE, 16'(k), 3'(k + 1)}; checks++;
         if (got !== exp) begin failures++; $display("FAIL b2b k=%0d got=%h exp=%h", k, got, exp); end
      end
      tick();
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_CHANGE, 16'd8, 3'b101}; checks++;
      if (got !== exp) begin failures++; $display("FAIL b2b_last got=%h exp=%h", got, exp); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         probe = 3'(i + 2);
         tick();
      end
      dump_off = 1'b1;
      tick();
      dump_off = 1'b0;
      got = {20'd0, out_valid, enabled}; exp = 22'd2; checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_queued got=%h exp=%h", got, exp); end
      rst = 1'b1; probe = 3'b011;
      tick();
      rst = 1'b0;
      got = {out_valid, out_kind, out_time, out_value}; exp = '0; checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_flush got=%h exp=%h", got, exp); end
      checks++;
      if ({enabled, overflow, drop_cnt} !== {1'b1, 1'b0, 8'd0}) begin
         failures++; $display("FAIL mid_state got=%b/%b/%0d exp=1/0/0", enabled, overflow, drop_cnt);
      end
      out_ready = 1'b1; probe = 3'b100;
      tick();
      got = {out_valid, out_kind, out_time, out_value}; exp = {1'b1, K_CHANGE, 16'd0, 3'b100}; checks++;
      if (got !== exp) begin failures++; $display("FAIL mid_ts0 got=%h exp=%h", got, exp); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_change();
      test_dump_off_on();
      test_snapshot_merge();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
